// File: rtl/fpga_ram_ctrl.sv
// Request/response front end for a single-port RAM with registered read data.
// Reads are credited against a 4-entry response FIFO so the buffer can never overflow.
module fpga_ram_ctrl #(
    parameter int DATAWIDTH = 2,
    parameter int ADDRWIDTH = 2
) (
    input  logic                 PortAClk,
    input  logic                 PortAReset,
    input  logic                 ReqValid,
    output logic                 ReqReady,
    input  logic                 ReqWrite,
    input  logic [ADDRWIDTH-1:0] ReqAddr,
    input  logic [DATAWIDTH-1:0] ReqData,
    output logic                 RspValid,
    input  logic                 RspReady,
    output logic [DATAWIDTH-1:0] RspData,
    output logic [ADDRWIDTH-1:0] RamAddr,
    output logic [DATAWIDTH-1:0] RamDataIn,
    output logic                 RamWriteEnable,
    input  logic [DATAWIDTH-1:0] RamDataOut,
    output logic                 Idle
);

    localparam int DEPTH = 4;

    logic [DATAWIDTH-1:0] fifoMem_q [DEPTH];
    logic [1:0]           wrPtr_q, wrPtr_d;
    logic [1:0]           rdPtr_q, rdPtr_d;
    logic [2:0]           count_q, count_d;
    logic                 inFlight_q, inFlight_d;

    logic [3:0]           creditsUsed;
    logic                 reqFire;
    logic                 readFire;
    logic                 push;
    logic                 pop;

    // A read holds a credit from acceptance until its response leaves the FIFO.
    assign creditsUsed    = {1'b0, count_q} + {3'b000, inFlight_q};
    assign ReqReady       = ~PortAReset & (creditsUsed < 4'd4);
    assign reqFire        = ReqValid & ReqReady;
    assign readFire       = reqFire & ~ReqWrite;

    assign RamAddr        = ReqAddr;
    assign RamDataIn      = ReqData;
    assign RamWriteEnable = reqFire & ReqWrite;

    assign push           = inFlight_q;
    assign RspValid       = (count_q != 3'd0);
    assign pop            = RspValid & RspReady;
    assign RspData        = fifoMem_q[rdPtr_q];
    assign Idle           = (count_q == 3'd0) & ~inFlight_q;

    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        inFlight_d = readFire;
        if (push) begin
            wrPtr_d = wrPtr_q + 2'd1;
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + 2'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge PortAClk) begin
        if (PortAReset) begin
            wrPtr_q    <= 2'd0;
            rdPtr_q    <= 2'd0;
            count_q    <= 3'd0;
            inFlight_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            inFlight_q <= inFlight_d;
        end
    end

    // Storage is left unreset; the pointers and count alone decide what is visible.
    always_ff @(posedge PortAClk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= RamDataOut;
        end
    end

endmodule

// File: doc/fpga_ram_ctrl.md
FPGA_RAM_CTRL -- requirements
Module: fpga_ram_ctrl

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 2, RAM word width in bits.
REQ-002 SHALL have parameter ADDRWIDTH, default 2, RAM address width in bits.
REQ-003 SHALL have port PortAClk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port PortAReset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ReqValid  input  1  request present.
REQ-006 SHALL have port ReqReady  output  1  request accepted when ReqValid & ReqReady.
REQ-007 SHALL have port ReqWrite  input  1  1 = write, 0 = read.
REQ-008 SHALL have port ReqAddr  input  ADDRWIDTH  request address.
REQ-009 SHALL have port ReqData  input  DATAWIDTH  write data; ignored for reads.
REQ-010 SHALL have port RspValid  output  1  read data available.
REQ-011 SHALL have port RspReady  input  1  response consumed when RspValid & RspReady.
REQ-012 SHALL have port RspData  output  DATAWIDTH  read data, head of response buffer.
REQ-013 SHALL have port RamAddr  output  ADDRWIDTH  to RAM port A address.
REQ-014 SHALL have port RamDataIn  output  DATAWIDTH  to RAM port A write data.
REQ-015 SHALL have port RamWriteEnable  output  1  to RAM port A write enable.
REQ-016 SHALL have port RamDataOut  input  DATAWIDTH  from RAM port A registered read data, valid the cycle after the address.
REQ-017 SHALL have port Idle  output  1  no read in flight and response buffer empty.

Function
REQ-018 SHALL drive RamAddr = ReqAddr and RamDataIn = ReqData combinationally, every cycle.
REQ-019 SHALL drive RamWriteEnable = ReqValid & ReqReady & ReqWrite; no other source.
REQ-020 SHALL hold a 4-entry response FIFO (DATAWIDTH wide) with 2-bit read/write pointers wrapping 3->0 and a 3-bit occupancy count 0..4.
REQ-021 SHALL hold a 1-bit InFlight flag, set on the edge after an accepted read, cleared on the edge after a cycle with no accepted read.
REQ-022 SHALL compute ReqReady = ~PortAReset & ((occupancy + InFlight) < 4), registered-state only; no combinational path from ReqValid, ReqWrite or RspReady.
REQ-023 SHALL apply the same credit gating to writes as to reads (ReqReady does not depend on ReqWrite).
REQ-024 SHALL push RamDataOut into the FIFO at the end of every cycle where InFlight = 1; a write accepted in that cycle does not affect the captured value.
REQ-025 SHALL never push when InFlight = 0, irrespective of RamDataOut changes after writes.
REQ-026 SHALL assert RspValid = (occupancy != 0) and RspData = FIFO[read pointer].
REQ-027 SHALL pop on RspValid & RspReady; simultaneous push and pop leaves occupancy unchanged, pointers both advance.
REQ-028 SHALL sustain one accepted request per cycle when RspReady is held high; read latency acceptance -> RspValid = 2 cycles.
REQ-029 SHALL return read responses in acceptance order; read after write to the same address returns the new data (RAM write-first).
REQ-030 SHALL hold RspData and RspValid stable while RspValid & ~RspReady.
REQ-031 SHALL drive Idle = (occupancy == 0) & ~InFlight.
REQ-032 SHALL never overflow: credit rule guarantees occupancy + InFlight <= 4.

Reset
REQ-033 SHALL, on PortAReset = 1 at a rising edge, clear occupancy, both pointers and InFlight to 0.
REQ-034 SHALL, in any cycle with PortAReset = 1, drive ReqReady = 0 and RamWriteEnable = 0; RspValid = 0 and Idle = 1 from the cycle after reset.
REQ-035 SHALL discard in-flight and buffered responses on reset mid-operation; RAM contents are not reset.
REQ-036 SHALL not reset FIFO storage contents.

Verification (DATAWIDTH=8, ADDRWIDTH=4)
REQ-037 SHALL cover: reset 2 cycles -> ReqReady 0 during, 1 after; RspValid 0, Idle 1.
REQ-038 SHALL cover: write 0xA5 to addr 3, read addr 3 next cycle -> RamWriteEnable high one cycle, RspData 0xA5 two cycles after read acceptance.
REQ-039 SHALL cover: back-to-back reads addr 0..7 with RspReady = 1 -> ReqReady never drops, 8 responses in order, one per cycle.
REQ-040 SHALL cover: RspReady = 0, issue reads continuously -> exactly 4 accepted, ReqReady low with occupancy 4, then RspReady = 1 drains in order and ReqReady reasserts.
REQ-041 SHALL cover: reset asserted with occupancy 2 and InFlight 1 -> after reset RspValid 0, Idle 1, no stale response ever emitted.
REQ-042 SHALL cover: write accepted in the cycle InFlight = 1 -> captured response equals prior read's data, not the write data.
